// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating an instruction-fetch port and a load/store port onto one byte-wide RAM.
// Optional MEM_CTRL_MEM_PRIO_EN: mem port always wins contention; otherwise round-robin.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  len_q;
  logic        isMem_q;
  logic        lastMem_q;
  logic [31:0] wdata_q;
  logic [31:0] readBuf_q;
  logic [31:0] readBuf_d;
  logic [31:0] ifData_q;
  logic [31:0] memRdata_q;
  logic        ifDone_q;
  logic        memDone_q;
  logic        wr_q;
  logic [7:0]  dout_q;
  logic [31:0] ramA_q;

  logic        grantMem;
  logic [2:0]  memN;
  logic [1:0]  capIdx;
  logic [7:0]  wrByte;

  // Arbitration, transfer length and the byte lanes used by the datapath.
  always_comb begin
`ifdef MEM_CTRL_MEM_PRIO_EN
    grantMem = mem_req;
`else
    grantMem = mem_req & (~if_req | ~lastMem_q);
`endif
    case (mem_len)
      2'd0:    memN = 3'd1;
      2'd1:    memN = 3'd2;
      default: memN = 3'd4;
    endcase
    capIdx    = 2'(cnt_q - 3'd2);
    readBuf_d = readBuf_q;
    if (cnt_q >= 3'd2) readBuf_d[{capIdx, 3'b000} +: 8] = ram_din;
    wrByte = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
  end

  // cnt_q is the index of the next byte address to present; reads capture
  // byte cnt_q-2 because RAM data trails its address by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      len_q      <= 3'd0;
      isMem_q    <= 1'b0;
      lastMem_q  <= 1'b0;
      wdata_q    <= 32'd0;
      readBuf_q  <= 32'd0;
      ifData_q   <= 32'd0;
      memRdata_q <= 32'd0;
      ifDone_q   <= 1'b0;
      memDone_q  <= 1'b0;
      wr_q       <= 1'b0;
      dout_q     <= 8'd0;
      ramA_q     <= 32'd0;
    end else if (rdy) begin
      ifDone_q  <= 1'b0;
      memDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!ifDone_q && !memDone_q && (if_req || mem_req)) begin
            isMem_q   <= grantMem;
            lastMem_q <= grantMem;
            ramA_q    <= grantMem ? mem_addr : if_addr;
            len_q     <= grantMem ? memN : 3'd4;
            wdata_q   <= mem_wdata;
            readBuf_q <= 32'd0;
            cnt_q     <= 3'd1;
            if (grantMem && mem_we) begin
              state_q <= WRITE;
              wr_q    <= 1'b1;
              dout_q  <= mem_wdata[7:0];
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (cnt_q < len_q) ramA_q <= ramA_q + 32'd1;
          if (cnt_q >= 3'd2) readBuf_q <= readBuf_d;
          if (cnt_q == len_q + 3'd1) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            if (isMem_q) begin
              memRdata_q <= readBuf_d;
              memDone_q  <= 1'b1;
            end else begin
              ifData_q <= readBuf_d;
              ifDone_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        WRITE: begin
          if (cnt_q < len_q) begin
            ramA_q <= ramA_q + 32'd1;
            dout_q <= wrByte;
            cnt_q  <= cnt_q + 3'd1;
          end else begin
            wr_q      <= 1'b0;
            memDone_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_data   = ifData_q;
  assign if_done   = ifDone_q;
  assign mem_rdata = memRdata_q;
  assign mem_done  = memDone_q;
  assign ram_dout  = dout_q;
  assign ram_a     = ramA_q;
  assign ram_wr    = wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected completions and RAM writes, a negedge monitor pops and compares.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req, mem_req, mem_we;
  logic [1:0]  mem_len;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_data, mem_rdata, ram_a;
  logic        if_done, mem_done, ram_wr;
  logic [7:0]  ram_din, ram_dout;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM with one cycle of read latency, frozen along with the controller when rdy is low.
  logic [7:0] ramArr [logic [31:0]];
  function automatic logic [7:0] rd(input logic [31:0] a);
    return ramArr.exists(a) ? ramArr[a] : 8'h00;
  endfunction
  always @(posedge clk) begin
    if (rdy) begin
      ram_din <= rd(ram_a);
      if (ram_wr) ramArr[ram_a] = ram_dout;
    end
  end

  typedef struct {
    bit          isMem;
    bit          hasData;
    logic [31:0] data;
    int          doneCyc;
  } resp_t;
  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;
  resp_t expQ[$];
  wr_t   wrQ[$];

  int errors = 0;
  int checks = 0;

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, need 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: every done pulse and every RAM write must match the head of its queue.
  initial begin
    resp_t e;
    wr_t   w;
    forever begin
      @(negedge clk);
      if (if_done === 1'b1 || mem_done === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected done", {30'd0, mem_done, if_done}, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("done port", {30'd0, mem_done, if_done}, e.isMem ? 32'd2 : 32'd1);
          checkOutput("done cycle", 32'(cyc), 32'(e.doneCyc));
          if (e.hasData) checkOutput("done data", e.isMem ? mem_rdata : if_data, e.data);
        end
      end
      if (ram_wr === 1'b1) begin
        if (wrQ.size() == 0) begin
          checkOutput("unexpected ram_wr addr", ram_a, 32'hFFFF_FFFF ^ ram_a);
        end else begin
          w = wrQ.pop_front();
          checkOutput("write addr", ram_a, w.a);
          checkOutput("write data", {24'd0, ram_dout}, {24'd0, w.d});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle;
    int k = 0;
    while (expQ.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    if (expQ.size() != 0) begin
      checkOutput("completion timeout, pending", 32'(expQ.size()), 32'd0);
      expQ.delete();
    end
    tick();
  endtask

  // Issue one request on an idle controller; inputs are scrambled right after acceptance.
  task automatic applyStimulus(input bit isMem, input bit we, input logic [1:0] len,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expData);
    int    n;
    int    acc;
    resp_t e;
    wr_t   w;
    n = !isMem ? 4 : (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    if (isMem) begin
      mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    tick();
    acc = cyc;
    if_req = 1'b0; mem_req = 1'b0;
    if_addr = ~if_addr; mem_addr = ~mem_addr; mem_wdata = ~mem_wdata; mem_len = ~mem_len;
    if (isMem && we) begin
      for (int i = 0; i < n; i++) begin
        w.a = addr + 32'(i);
        w.d = wdata[8*i +: 8];
        wrQ.push_back(w);
      end
      e = '{isMem: 1'b1, hasData: 1'b0, data: 32'd0, doneCyc: acc + n};
    end else begin
      e = '{isMem: isMem, hasData: 1'b1, data: expData, doneCyc: acc + n + 1};
    end
    expQ.push_back(e);
    mem_we = 1'b0;
  endtask

  // Both ports request on the same edge: mem does a byte load, fetch a word read.
  task automatic contend(input bit memFirst, input logic [31:0] memAddr, input logic [31:0] memExp,
                         input logic [31:0] ifAddr, input logic [31:0] ifExp);
    int acc;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = memAddr;
    if_req = 1'b1; if_addr = ifAddr;
    tick();
    acc = cyc;
    if (memFirst) begin
      mem_req = 1'b0;
      expQ.push_back('{isMem: 1'b1, hasData: 1'b1, data: memExp, doneCyc: acc + 2});
      while (cyc < acc + 4) tick();
      if_req = 1'b0;
      expQ.push_back('{isMem: 1'b0, hasData: 1'b1, data: ifExp, doneCyc: acc + 9});
    end else begin
      if_req = 1'b0;
      expQ.push_back('{isMem: 1'b0, hasData: 1'b1, data: ifExp, doneCyc: acc + 5});
      while (cyc < acc + 7) tick();
      mem_req = 1'b0;
      expQ.push_back('{isMem: 1'b1, hasData: 1'b1, data: memExp, doneCyc: acc + 9});
    end
  endtask

  initial begin
    int acc;
    rst = 1'b1; rdy = 1'b1;
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'd0;
    if_addr = 32'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    ramArr[32'h100] = 8'h13; ramArr[32'h101] = 8'h05;
    ramArr[32'h102] = 8'h10; ramArr[32'h103] = 8'h00;
    ramArr[32'h300] = 8'hEF; ramArr[32'h301] = 8'hBE;
    ramArr[32'h302] = 8'hAD; ramArr[32'h303] = 8'hDE;
    ramArr[32'h80]  = 8'h80;
    ramArr[32'h1]   = 8'h11; ramArr[32'h2] = 8'h22;
    tick(); tick();
    checkOutput("reset if_data", if_data, 32'd0);
    checkOutput("reset mem_rdata", mem_rdata, 32'd0);
    checkOutput("reset ram_a", ram_a, 32'd0);
    checkOutput("reset ram_wr", {31'd0, ram_wr}, 32'd0);
    checkOutput("reset dones", {30'd0, mem_done, if_done}, 32'd0);
    rst = 1'b0;
    tick();

    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0000_0100, 32'd0, 32'h0010_0513);
    waitIdle();
    applyStimulus(1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'hAABB_CCDD, 32'd0);
    waitIdle();
    checkOutput("mem_rdata held over store", mem_rdata, 32'd0);
    checkOutput("if_data held", if_data, 32'h0010_0513);
    applyStimulus(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'd0, 32'h2211_CCDD);
    waitIdle();
    applyStimulus(1'b1, 1'b0, 2'd1, 32'h0000_0101, 32'd0, 32'h0000_1005);
    waitIdle();
    applyStimulus(1'b1, 1'b0, 2'd3, 32'h0000_0100, 32'd0, 32'h0010_0513);
    waitIdle();

    rst = 1'b1; tick(); rst = 1'b0; tick();
    contend(1'b1, 32'h101, 32'h05, 32'h100, 32'h0010_0513);
    waitIdle();
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0000_0102, 32'd0, 32'h0000_0010);
    waitIdle();
`ifdef MEM_CTRL_MEM_PRIO_EN
    contend(1'b1, 32'h101, 32'h05, 32'h300, 32'hDEAD_BEEF);
`else
    contend(1'b0, 32'h101, 32'h05, 32'h300, 32'hDEAD_BEEF);
`endif
    waitIdle();

    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h80;
    tick();
    acc = cyc;
    mem_req = 1'b0; mem_addr = 32'h100;
    expQ.push_back('{isMem: 1'b1, hasData: 1'b1, data: 32'h0000_0080, doneCyc: acc + 5});
    tick();
    rdy = 1'b0;
    tick(); tick(); tick();
    rdy = 1'b1;
    waitIdle();

    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h200; mem_wdata = 32'h4433_2211;
    tick();
    mem_req = 1'b0; mem_we = 1'b0;
    wrQ.push_back('{a: 32'h200, d: 8'h11});
    tick();
    wrQ.push_back('{a: 32'h201, d: 8'h22});
    rst = 1'b1;
    tick();
    checkOutput("abort ram_wr", {31'd0, ram_wr}, 32'd0);
    checkOutput("abort ram_a", ram_a, 32'd0);
    checkOutput("abort mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    tick(); tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0000_0300, 32'd0, 32'hDEAD_BEEF);
    waitIdle();
    tick(); tick();
    checkOutput("write queue drained", 32'(wrQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
